adder_serial: RTL and testbench



---
 rtl/adder_serial_pkg.sv | 30 +++
 rtl/adder_serial_digit.sv | 24 ++
 rtl/adder_serial.sv | 145 ++++++++++++++
 tb/tb_adder_serial.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_serial_pkg.sv
// adder_pkg: shared definitions for the digit-serial adder.
//   - ST_IDLE / ST_RUN / ST_DONE : 2-bit state encodings
//   - state_e                    : FSM state type built on those encodings
//   - steps_f / cnt_w_f          : constant helpers for the RUN-step count and
//                                  the step-counter width (minimum 1 bit)
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Number of RUN cycles needed to consume a WIDTH-bit operand.
  function automatic int steps_f(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width able to hold STEPS-1; a single-step build still gets 1 bit.
  function automatic int cnt_w_f(input int width, input int digit);
    int s;
    s = width / digit;
    return (s <= 1) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/adder_serial_digit.sv
// adder_digit: combinational DIGIT-bit ripple slice used by the serial adder.
// Ports:
//   x, y : DIGIT-bit addends
//   ci   : carry-in
//   s    : DIGIT-bit sum
//   co   : carry-out
module adder_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // Widen by one bit so the carry falls out of the top of the addition.
  logic [DIGIT:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  assign s    = full[DIGIT-1:0];
  assign co   = full[DIGIT];

endmodule

// File: rtl/adder_serial.sv
// adder_serial: digit-serial adder, DIGIT bits per clock, valid/ready on both
// sides, one operation in flight.
// Optional build macro: ADDER_SERIAL_SUB_EN adds a 'sub' input; when set at
// acceptance the block computes a - b (sum[WIDTH] = 1 means no borrow).
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : operand set presented
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry-in
//   sub       : (ADDER_SERIAL_SUB_EN only) subtract request
//   out_valid : result available, held until out_ready
//   out_ready : consumer accepts the result
//   sum       : WIDTH+1 bit result, MSB is the carry-out
module adder_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int STEPS = steps_f(WIDTH, DIGIT);
  localparam int CW    = cnt_w_f(WIDTH, DIGIT);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] ps_q;
  logic [WIDTH-1:0] ps_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;

  // Operand B and initial carry as they are captured at acceptance.
  logic [WIDTH-1:0] b_lat;
  logic             c_lat;

  adder_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x (a_sh_q[DIGIT-1:0]),
    .y (b_sh_q[DIGIT-1:0]),
    .ci(carry_q),
    .s (dig_s),
    .co(dig_co)
  );

  // Subtraction is a + ~b + 1: invert B on capture and force the carry.
  always_comb begin
    b_lat = b;
    c_lat = cin;
`ifdef ADDER_SERIAL_SUB_EN
    if (sub) begin
      b_lat = ~b;
      c_lat = 1'b1;
    end
`endif
  end

  // New digits enter the partial sum from the top, so after STEPS shifts the
  // least-significant digit has reached bit 0.
  always_comb begin
    ps_d                   = ps_q >> DIGIT;
    ps_d[WIDTH-1 -: DIGIT] = dig_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      ps_q        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b_lat;
            carry_q    <= c_lat;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_q >> DIGIT;
          b_sh_q  <= b_sh_q >> DIGIT;
          ps_q    <= ps_d;
          carry_q <= dig_co;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(STEPS - 1)) begin
            // Final digit: capture the result straight from this edge's slice.
            sum_q       <= {dig_co, ps_d};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_valid is deliberately ignored here; an operand offered on the
          // handshake edge is taken on the following IDLE cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_adder_serial.sv
module tb_adder_serial;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;

  // index 0: DIGIT=2, 1: DIGIT=8, 2: DIGIT=1
  logic       rdy [3];
  logic       vld [3];
  logic [8:0] sm  [3];

  int lat_exp [3] = '{4, 1, 8};

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_serial #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(sub),
`endif
    .out_valid(vld[0]), .out_ready(out_ready), .sum(sm[0]));

  adder_serial #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(sub),
`endif
    .out_valid(vld[1]), .out_ready(out_ready), .sum(sm[1]));

  adder_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(sub),
`endif
    .out_valid(vld[2]), .out_ready(out_ready), .sum(sm[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  // Reference: plain integer arithmetic; subtraction as difference + no-borrow flag.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    int   r;
    logic [7:0] d;
    if (s) begin
      d = x - y;
      return {(x >= y) ? 1'b1 : 1'b0, d};
    end
    r = int'(x) + int'(y) + int'(c);
    return r[8:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", {31'd0, rdy[0] && rdy[1] && rdy[2]}, 32'd1);
  endtask

  // Called #1 after an acceptance edge; watches all three instances.
  task automatic collect(input string name, input logic [8:0] exp);
    bit seen [3];
    int lat  [3];
    logic [8:0] got [3];
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin seen[i] = 0; lat[i] = 0; got[i] = '0; end
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (vld[i] && !seen[i]) begin
          seen[i] = 1; lat[i] = n; got[i] = sm[i];
        end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_seen%0d", name, i), {31'd0, seen[i]}, 32'd1);
      chk($sformatf("%s_sum%0d", name, i), {23'd0, got[i]}, {23'd0, exp});
      chk($sformatf("%s_lat%0d", name, i), lat[i], lat_exp[i]);
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts);
    wait_idle();
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom;
    collect(name, model(ta, tb, tc, ts));
  endtask

  vec_t vecs [6];
  logic [8:0] held;

  initial begin
    vecs[0] = '{8'h2F, 8'h31, 1'b0, 9'h060};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 9'h001};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 9'h100};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), {31'd0, rdy[i]}, 32'd1);
      chk($sformatf("rst_vld%0d", i), {31'd0, vld[i]}, 32'd0);
      chk($sformatf("rst_sum%0d", i), {23'd0, sm[i]}, 32'd0);
    end

    // Directed table with fixed expected sums.
    foreach (vecs[i]) begin
      wait_idle();
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Backpressure: hold DONE for 10 cycles with in_valid noise.
    wait_idle();
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_vld_rise", {31'd0, vld[0]}, 32'd1);
    chk("bp_sum", {23'd0, sm[0]}, 32'h047);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0]; a = $urandom; b = $urandom; cin = $urandom;
      @(posedge clk); #1;
      chk("bp_hold_vld", {31'd0, vld[0]}, 32'd1);
      chk("bp_hold_rdy", {31'd0, rdy[0]}, 32'd0);
      chk("bp_hold_sum", {23'd0, sm[0]}, 32'h047);
    end
    // Simultaneous out_ready and in_valid: only the output handshake completes.
    a = 8'h03; b = 8'h05; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("sim_rdy", {31'd0, rdy[0]}, 32'd1);
    chk("sim_vld", {31'd0, vld[0]}, 32'd0);
    chk("sim_sum_kept", {23'd0, sm[0]}, 32'h047);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sim_accepted", {31'd0, rdy[0]}, 32'd0);
    collect("after_bp", 9'h008);

`ifdef ADDER_SERIAL_SUB_EN
    run_op("sub_neg", 8'h05, 8'h0A, 1'b0, 1'b1);
    run_op("sub_pos", 8'h0A, 8'h05, 1'b1, 1'b1);
    run_op("sub_off", 8'h03, 8'h04, 1'b1, 1'b0);
`endif

    // Randomized against the arithmetic model.
    for (int r = 0; r < 200; r++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      ra = $urandom; rb = $urandom; rc = $urandom;
`ifdef ADDER_SERIAL_SUB_EN
      rs = $urandom;
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rnd%0d", r), ra, rb, rc, rs);
    end

    // Reset during RUN aborts the operation.
    wait_idle();
    out_ready = 1'b0; sub = 1'b0;
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_rdy%0d", i), {31'd0, rdy[i]}, 32'd1);
      chk($sformatf("mid_rst_vld%0d", i), {31'd0, vld[i]}, 32'd0);
      chk($sformatf("mid_rst_sum%0d", i), {23'd0, sm[i]}, 32'd0);
    end
    held = 9'h000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("no_stray_vld", {29'd0, vld[0], vld[1], vld[2]}, 32'd0);
      chk("no_stray_sum", {23'd0, sm[0]}, {23'd0, held});
    end
    run_op("post_rst", 8'h2F, 8'h31, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
